// File: rtl/linear_regression_engine.sv
`default_nettype none
// ============================================================================
// Module      : linear_regression_engine
// Description : Buffers (x, y) fixed-point samples and fits y = B0 + B1*x by
//               least squares, using one shared sequential signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
module linear_regression_engine #(
  parameter int W     = 20,
  parameter int FRAC  = 10,
  parameter int DEPTH = 150,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  inX,
  input  logic [W-1:0]  inY,
  input  logic          inValid,
  output logic          inReady,
  input  logic          calcStart,
  input  logic          clear,
  output logic [CW-1:0] sampleCount,
  output logic          busy,
  output logic          calcReady,
  output logic          err,
  output logic [W-1:0]  outB0,
  output logic [W-1:0]  outB1
);
  localparam int AW   = W + CW;
  localparam int SW   = 2 * W + CW;
  localparam int DIVW = SW + FRAC;
  localparam int DCW  = $clog2(DIVW + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUM    = 3'd1,
    MEANX  = 3'd2,
    MEANY  = 3'd3,
    DEV    = 3'd4,
    DIVB1  = 3'd5,
    CALCB0 = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t r_state, w_next;

  logic signed [W-1:0]  r_bufX [DEPTH];
  logic signed [W-1:0]  r_bufY [DEPTH];
  logic [CW-1:0]        r_count, r_idx;
  logic signed [AW-1:0] r_sumX, r_sumY;
  logic signed [SW-1:0] r_ssxx, r_ssxy;
  logic signed [W-1:0]  r_xbar, r_ybar, r_b1;
  logic                 r_degen;
  logic [W-1:0]         r_outB0, r_outB1;
  logic                 r_err;

  logic [DIVW-1:0]      r_dvd, r_quo;
  logic [SW-1:0]        r_dvs, r_rem;
  logic                 r_neg, r_divAct;
  logic [DCW-1:0]       r_divCnt;

  logic signed [W-1:0]    w_curX, w_curY;
  logic                   w_accept, w_last, w_divDone;
  logic signed [W:0]      w_dx, w_dy;
  logic signed [2*W+1:0]  w_pxx, w_pxy;
  logic signed [AW-1:0]   w_sumSel;
  logic [AW-1:0]          w_magSum;
  logic [SW-1:0]          w_magXx, w_magXy;
  logic [SW:0]            w_remSh;
  logic                   w_geq, w_over, w_b0Fits;
  logic [W-1:0]           w_meanQ, w_b1Q, w_b0Sat;
  logic signed [2*W-1:0]  w_prod;
  logic signed [2*W:0]    w_b0Wide;

  assign w_curX    = r_bufX[r_idx[IW-1:0]];
  assign w_curY    = r_bufY[r_idx[IW-1:0]];
  assign w_accept  = (r_state == IDLE) && !calcStart && inValid && inReady;
  assign w_last    = (r_idx == r_count - CW'(1));
  assign w_divDone = r_divAct && (r_divCnt == '0);

  assign w_dx  = {w_curX[W-1], w_curX} - {r_xbar[W-1], r_xbar};
  assign w_dy  = {w_curY[W-1], w_curY} - {r_ybar[W-1], r_ybar};
  assign w_pxx = (w_dx * w_dx) >>> FRAC;
  assign w_pxy = (w_dx * w_dy) >>> FRAC;

  // Divider works on magnitudes; the sign is reapplied to the quotient.
  assign w_sumSel = (r_state == MEANX) ? r_sumX : r_sumY;
  assign w_magSum = w_sumSel[AW-1] ? -w_sumSel : w_sumSel;
  assign w_magXx  = r_ssxx[SW-1] ? -r_ssxx : r_ssxx;
  assign w_magXy  = r_ssxy[SW-1] ? -r_ssxy : r_ssxy;
  assign w_remSh  = {r_rem, r_dvd[DIVW-1]};
  assign w_geq    = (w_remSh >= {1'b0, r_dvs});

  assign w_meanQ = r_neg ? -r_quo[W-1:0] : r_quo[W-1:0];
  assign w_over  = r_neg ? ((|r_quo[DIVW-1:W]) || (r_quo[W-1] && (|r_quo[W-2:0])))
                         : (|r_quo[DIVW-1:W-1]);
  assign w_b1Q   = w_over ? (r_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                          : (r_neg ? -r_quo[W-1:0] : r_quo[W-1:0]);

  assign w_prod   = (r_b1 * r_xbar) >>> FRAC;
  assign w_b0Wide = (2*W+1)'(r_ybar) - (2*W+1)'(w_prod);
  assign w_b0Fits = (&w_b0Wide[2*W:W-1]) || !(|w_b0Wide[2*W:W-1]);
  assign w_b0Sat  = w_b0Fits ? w_b0Wide[W-1:0]
                             : (w_b0Wide[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (calcStart) w_next = (r_count == '0) ? DONE : SUM;
      SUM:     if (w_last) w_next = MEANX;
      MEANX:   if (w_divDone) w_next = MEANY;
      MEANY:   if (w_divDone) w_next = DEV;
      DEV:     if (w_last) w_next = DIVB1;
      DIVB1:   if (w_divDone || (!r_divAct && (r_ssxx == '0))) w_next = CALCB0;
      CALCB0:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bufX[r_count[IW-1:0]] <= inX;
      r_bufY[r_count[IW-1:0]] <= inY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_idx    <= '0;
      r_outB0  <= '0;
      r_outB1  <= '0;
      r_err    <= 1'b0;
      r_divAct <= 1'b0;
    end else begin
      if (r_divAct && (r_divCnt != '0)) begin
        r_rem    <= w_geq ? SW'(w_remSh - {1'b0, r_dvs}) : SW'(w_remSh);
        r_quo    <= {r_quo[DIVW-2:0], w_geq};
        r_dvd    <= {r_dvd[DIVW-2:0], 1'b0};
        r_divCnt <= r_divCnt - DCW'(1);
      end
      unique case (r_state)
        IDLE: begin
          r_idx    <= '0;
          r_sumX   <= '0;
          r_sumY   <= '0;
          r_ssxx   <= '0;
          r_ssxy   <= '0;
          r_divAct <= 1'b0;
          if (calcStart) begin
            if (r_count == '0) begin
              r_outB0 <= '0;
              r_outB1 <= '0;
              r_err   <= 1'b1;
            end
          end else if (w_accept) begin
            r_count <= r_count + CW'(1);
          end else if (clear) begin
            r_count <= '0;
          end
        end
        SUM: begin
          r_sumX <= r_sumX + AW'(w_curX);
          r_sumY <= r_sumY + AW'(w_curY);
          r_idx  <= w_last ? '0 : r_idx + CW'(1);
        end
        MEANX, MEANY: begin
          if (!r_divAct) begin
            r_dvd    <= {w_magSum, {(DIVW-AW){1'b0}}};
            r_dvs    <= SW'(r_count);
            r_rem    <= '0;
            r_quo    <= '0;
            r_neg    <= w_sumSel[AW-1];
            r_divCnt <= DCW'(AW);
            r_divAct <= 1'b1;
          end else if (r_divCnt == '0) begin
            if (r_state == MEANX) r_xbar <= w_meanQ;
            else                  r_ybar <= w_meanQ;
            r_divAct <= 1'b0;
            r_idx    <= '0;
          end
        end
        DEV: begin
          r_ssxx <= r_ssxx + SW'(w_pxx);
          r_ssxy <= r_ssxy + SW'(w_pxy);
          r_idx  <= w_last ? '0 : r_idx + CW'(1);
        end
        DIVB1: begin
          if (!r_divAct) begin
            if (r_ssxx == '0) begin
              r_b1    <= '0;
              r_degen <= 1'b1;
            end else begin
              r_dvd    <= {w_magXy, {FRAC{1'b0}}};
              r_dvs    <= w_magXx;
              r_rem    <= '0;
              r_quo    <= '0;
              r_neg    <= r_ssxy[SW-1] ^ r_ssxx[SW-1];
              r_divCnt <= DCW'(DIVW);
              r_divAct <= 1'b1;
              r_degen  <= 1'b0;
            end
          end else if (r_divCnt == '0) begin
            r_b1     <= w_b1Q;
            r_divAct <= 1'b0;
          end
        end
        CALCB0: begin
          r_outB0 <= w_b0Sat;
          r_outB1 <= r_b1;
          r_err   <= r_degen;
        end
        default: ;
      endcase
    end
  end

  assign inReady     = (r_state == IDLE) && (r_count < CW'(DEPTH));
  assign sampleCount = r_count;
  assign busy        = (r_state != IDLE);
  assign calcReady   = (r_state == DONE);
  assign err         = r_err;
  assign outB0       = r_outB0;
  assign outB1       = r_outB1;
endmodule
`default_nettype wire

// File: tb/tb_linear_regression_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_linear_regression_engine
// Description : Self-checking bench comparing the engine against an
//               arithmetic least-squares reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linear_regression_engine;
  localparam int W    = 20;
  localparam int FRAC = 10;
  localparam int CW   = 8;
  localparam int CW4  = 3;
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (W-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] inX = '0, inY = '0;
  logic inValid = 1'b0, calcStart = 1'b0, clear = 1'b0;
  logic inValid4 = 1'b0, calcStart4 = 1'b0, clear4 = 1'b0;
  logic inReady, busy, calcReady, err;
  logic [CW-1:0] sampleCount;
  logic [W-1:0] outB0, outB1;
  logic inReady4, busy4, calcReady4, err4;
  logic [CW4-1:0] sampleCount4;
  logic [W-1:0] outB04, outB14;

  int nChecks = 0;
  int nPass = 0;
  longint qx[$], qy[$];

  always #5 clk = ~clk;

  linear_regression_engine #(.W(W), .FRAC(FRAC), .DEPTH(150)) dut (
    .clk(clk), .rst(rst), .inX(inX), .inY(inY), .inValid(inValid), .inReady(inReady),
    .calcStart(calcStart), .clear(clear), .sampleCount(sampleCount), .busy(busy),
    .calcReady(calcReady), .err(err), .outB0(outB0), .outB1(outB1)
  );

  linear_regression_engine #(.W(W), .FRAC(FRAC), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .inX(inX), .inY(inY), .inValid(inValid4), .inReady(inReady4),
    .calcStart(calcStart4), .clear(clear4), .sampleCount(sampleCount4), .busy(busy4),
    .calcReady(calcReady4), .err(err4), .outB0(outB04), .outB1(outB14)
  );

  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Least-squares fit straight from the defining sums, in 64-bit arithmetic.
  function automatic void model(output longint b0, output longint b1, output bit e);
    longint n, sx, sy, xb, yb, sxx, sxy, dx, dy;
    n = longint'(qx.size());
    if (n == 0) begin
      b0 = 0; b1 = 0; e = 1'b1;
      return;
    end
    sx = 0; sy = 0; sxx = 0; sxy = 0;
    foreach (qx[i]) begin sx += qx[i]; sy += qy[i]; end
    xb = sx / n;
    yb = sy / n;
    foreach (qx[i]) begin
      dx = qx[i] - xb;
      dy = qy[i] - yb;
      sxx += (dx * dx) >>> FRAC;
      sxy += (dx * dy) >>> FRAC;
    end
    if (sxx == 0) begin b1 = 0; e = 1'b1; end
    else begin b1 = sat((sxy * (longint'(1) << FRAC)) / sxx); e = 1'b0; end
    b0 = sat(yb - ((b1 * xb) >>> FRAC));
  endfunction

  task automatic pushMain(input longint x, input longint y);
    @(negedge clk);
    inX = x[W-1:0]; inY = y[W-1:0]; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    qx.push_back(x); qy.push_back(y);
  endtask

  task automatic clearMain();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    qx.delete(); qy.delete();
  endtask

  task automatic runCalc(output int lat, output bit got);
    int budget;
    budget = 2 * qx.size() + 3 * (2*W + CW) + 10;
    @(negedge clk); calcStart = 1'b1;
    @(negedge clk); calcStart = 1'b0;
    lat = 1; got = 1'b0;
    while (!got && lat <= budget) begin
      if (calcReady === 1'b1) got = 1'b1;
      else begin @(negedge clk); lat++; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nChecks++; if (sampleCount !== '0) $display("FAIL reset_count: got %0d expected 0", sampleCount); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else nPass++;
    nChecks++; if (calcReady !== 1'b0) $display("FAIL reset_calcReady: got %b expected 0", calcReady); else nPass++;
    nChecks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else nPass++;
    nChecks++; if (outB0 !== '0 || outB1 !== '0) $display("FAIL reset_outs: got %0d/%0d expected 0/0", outB0, outB1); else nPass++;
    nChecks++; if (inReady !== 1'b1) $display("FAIL reset_inReady: got %b expected 1", inReady); else nPass++;
    nChecks++; if (sampleCount4 !== '0) $display("FAIL reset_count4: got %0d expected 0", sampleCount4); else nPass++;
  endtask

  task automatic test_empty();
    int lat; bit got;
    runCalc(lat, got);
    nChecks++; if (!got) $display("FAIL empty_ready: calcReady absent after %0d cycles, expected pulse", lat); else nPass++;
    nChecks++; if (err !== 1'b1) $display("FAIL empty_err: got %b expected 1", err); else nPass++;
    nChecks++; if (outB0 !== '0 || outB1 !== '0) $display("FAIL empty_outs: got %0d/%0d expected 0/0", outB0, outB1); else nPass++;
    @(negedge clk);
    nChecks++; if (calcReady !== 1'b0 || busy !== 1'b0) $display("FAIL empty_pulse: calcReady %b busy %b expected 0 0", calcReady, busy); else nPass++;
  endtask

  task automatic test_basic();
    int lat; bit got;
    pushMain(1024, 3072); pushMain(2048, 5120); pushMain(3072, 7168);
    nChecks++; if (sampleCount !== 8'd3) $display("FAIL basic_count: got %0d expected 3", sampleCount); else nPass++;
    runCalc(lat, got);
    nChecks++; if (!got) $display("FAIL basic_ready: calcReady absent after %0d cycles, expected pulse", lat); else nPass++;
    nChecks++; if (outB1 !== 20'd2048) $display("FAIL basic_b1: got %0d expected 2048", $signed(outB1)); else nPass++;
    nChecks++; if (outB0 !== 20'd1024) $display("FAIL basic_b0: got %0d expected 1024", $signed(outB0)); else nPass++;
    nChecks++; if (err !== 1'b0) $display("FAIL basic_err: got %b expected 0", err); else nPass++;
    @(negedge clk);
    nChecks++; if (calcReady !== 1'b0) $display("FAIL basic_pulse: got %b expected 0", calcReady); else nPass++;
  endtask

  task automatic test_repeat();
    int lat, extra; bit got;
    @(negedge clk); calcStart = 1'b1;
    @(negedge clk); calcStart = 1'b0; clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    repeat (6) @(negedge clk);
    calcStart = 1'b1;
    @(negedge clk); calcStart = 1'b0;
    lat = 11; got = 1'b0;
    while (!got && lat <= 2*3 + 3*(2*W+CW) + 10) begin
      if (calcReady === 1'b1) got = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    nChecks++; if (!got) $display("FAIL repeat_ready: calcReady absent after %0d cycles, expected pulse", lat); else nPass++;
    nChecks++; if (outB1 !== 20'd2048 || outB0 !== 20'd1024 || err !== 1'b0)
      $display("FAIL repeat_result: got b0 %0d b1 %0d err %b expected 1024 2048 0", $signed(outB0), $signed(outB1), err); else nPass++;
    nChecks++; if (sampleCount !== 8'd3) $display("FAIL repeat_count: got %0d expected 3", sampleCount); else nPass++;
    extra = 0;
    for (int i = 0; i < 150; i++) begin @(negedge clk); if (calcReady === 1'b1) extra++; end
    nChecks++; if (extra != 0) $display("FAIL busy_start_ignored: got %0d extra pulses expected 0", extra); else nPass++;
  endtask

  task automatic test_clear();
    clearMain();
    nChecks++; if (sampleCount !== '0 || inReady !== 1'b1) $display("FAIL clear_count: got %0d ready %b expected 0 1", sampleCount, inReady); else nPass++;
  endtask

  task automatic test_degenerate();
    int lat; bit got;
    pushMain(2048, 1024); pushMain(2048, 2048); pushMain(2048, 3072);
    runCalc(lat, got);
    nChecks++; if (!got) $display("FAIL degen_ready: calcReady absent after %0d cycles, expected pulse", lat); else nPass++;
    nChecks++; if (err !== 1'b1) $display("FAIL degen_err: got %b expected 1", err); else nPass++;
    nChecks++; if (outB1 !== '0) $display("FAIL degen_b1: got %0d expected 0", $signed(outB1)); else nPass++;
    nChecks++; if (outB0 !== 20'd2048) $display("FAIL degen_b0: got %0d expected 2048", $signed(outB0)); else nPass++;
  endtask

  task automatic test_random();
    int lat, n; bit got, e; longint b0, b1, x, y; logic [W-1:0] rx, ry, w0, w1;
    for (int r = 0; r < 6; r++) begin
      clearMain();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        if (r % 2 == 0) begin
          rx = W'($urandom); ry = W'($urandom);
          x = longint'($signed(rx)); y = longint'($signed(ry));
        end else begin
          x = longint'($urandom_range(0, 8191)) - 4096;
          y = ((x * 3) >>> 1) + longint'($urandom_range(0, 255)) - 128;
        end
        pushMain(x, y);
      end
      model(b0, b1, e);
      w0 = b0[W-1:0]; w1 = b1[W-1:0];
      runCalc(lat, got);
      nChecks++; if (!got) $display("FAIL rand%0d_ready: calcReady absent after %0d cycles, expected pulse", r, lat); else nPass++;
      nChecks++; if (outB1 !== w1) $display("FAIL rand%0d_b1: got %0d expected %0d", r, $signed(outB1), b1); else nPass++;
      nChecks++; if (outB0 !== w0) $display("FAIL rand%0d_b0: got %0d expected %0d", r, $signed(outB0), b0); else nPass++;
      nChecks++; if (err !== e) $display("FAIL rand%0d_err: got %b expected %b", r, err, e); else nPass++;
    end
  endtask

  task automatic test_priority();
    int lat, cnt; bit got, e; longint b0, b1; logic [W-1:0] w0, w1;
    cnt = qx.size();
    model(b0, b1, e);
    w0 = b0[W-1:0]; w1 = b1[W-1:0];
    @(negedge clk);
    calcStart = 1'b1; clear = 1'b1; inValid = 1'b1; inX = 20'h7FFFF; inY = 20'h80000;
    @(negedge clk);
    calcStart = 1'b0; clear = 1'b0; inValid = 1'b0;
    nChecks++; if (busy !== 1'b1) $display("FAIL prio_busy: got %b expected 1", busy); else nPass++;
    nChecks++; if (sampleCount !== CW'(cnt)) $display("FAIL prio_count: got %0d expected %0d", sampleCount, cnt); else nPass++;
    lat = 1; got = 1'b0;
    while (!got && lat <= 2*cnt + 3*(2*W+CW) + 10) begin
      if (calcReady === 1'b1) got = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    nChecks++; if (!got) $display("FAIL prio_ready: calcReady absent after %0d cycles, expected pulse", lat); else nPass++;
    nChecks++; if (outB0 !== w0 || outB1 !== w1 || err !== e)
      $display("FAIL prio_result: got %0d/%0d/%b expected %0d/%0d/%b", $signed(outB0), $signed(outB1), err, b0, b1, e); else nPass++;
  endtask

  task automatic test_full();
    int lat; bit got, e; longint b0, b1, x, y; logic [W-1:0] w0, w1;
    qx.delete(); qy.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        nChecks++; if (inReady4 !== 1'b0 || sampleCount4 !== 3'd4)
          $display("FAIL full_ready: got ready %b count %0d expected 0 4", inReady4, sampleCount4); else nPass++;
        x = MINV; y = MAXV;
      end else begin
        x = longint'($urandom_range(0, 8191)) - 4096;
        y = 2 * x + longint'($urandom_range(0, 511));
        qx.push_back(x); qy.push_back(y);
      end
      inX = x[W-1:0]; inY = y[W-1:0]; inValid4 = 1'b1;
    end
    @(negedge clk); inValid4 = 1'b0;
    nChecks++; if (sampleCount4 !== 3'd4) $display("FAIL full_count: got %0d expected 4", sampleCount4); else nPass++;
    model(b0, b1, e);
    w0 = b0[W-1:0]; w1 = b1[W-1:0];
    calcStart4 = 1'b1;
    @(negedge clk); calcStart4 = 1'b0;
    lat = 1; got = 1'b0;
    while (!got && lat <= 2*4 + 3*(2*W+CW4) + 10) begin
      if (calcReady4 === 1'b1) got = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    nChecks++; if (!got) $display("FAIL full_calc_ready: calcReady absent after %0d cycles, expected pulse", lat); else nPass++;
    nChecks++; if (outB04 !== w0 || outB14 !== w1 || err4 !== e)
      $display("FAIL full_result: got %0d/%0d/%b expected %0d/%0d/%b", $signed(outB04), $signed(outB14), err4, b0, b1, e); else nPass++;
  endtask

  task automatic test_reset_abort();
    int seen;
    clearMain();
    for (int i = 0; i < 10; i++) pushMain(longint'(i) * 512 - 2048, longint'($urandom_range(0, 4095)));
    @(negedge clk); calcStart = 1'b1;
    @(negedge clk); calcStart = 1'b0;
    repeat (10 + 2*(W+CW) + 8) @(negedge clk);
    nChecks++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", busy); else nPass++;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    nChecks++; if (busy !== 1'b0 || sampleCount !== '0)
      $display("FAIL abort_state: got busy %b count %0d expected 0 0", busy, sampleCount); else nPass++;
    nChecks++; if (outB0 !== '0 || outB1 !== '0 || err !== 1'b0 || calcReady !== 1'b0)
      $display("FAIL abort_outs: got %0d/%0d/%b/%b expected 0/0/0/0", outB0, outB1, err, calcReady); else nPass++;
    seen = 0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (calcReady === 1'b1) seen++; end
    nChecks++; if (seen != 0) $display("FAIL abort_no_ready: got %0d pulses expected 0", seen); else nPass++;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_basic();
    test_repeat();
    test_clear();
    test_degenerate();
    test_random();
    test_priority();
    test_full();
    test_reset_abort();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/linear_regression_engine.md
LINEAR_REGRESSION_ENGINE -- requirements
Module: linear_regression_engine

Interface
REQ-001 SHALL have parameter W, default 20: sample and coefficient width, signed two's complement.
REQ-002 SHALL have parameter FRAC, default 10: fractional bits of every sample and coefficient (fixed-point Q(W-FRAC).FRAC).
REQ-003 SHALL have parameter DEPTH, default 150: maximum samples per data set; CW = clog2(DEPTH+1).
REQ-004 SHALL have port clk, input, 1: single clock, all state on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port inX, input, W: sample x value.
REQ-007 SHALL have port inY, input, W: sample y value.
REQ-008 SHALL have port inValid, input, 1: sample pair present.
REQ-009 SHALL have port inReady, output, 1: engine accepts a sample this cycle.
REQ-010 SHALL have port calcStart, input, 1: single-cycle pulse requesting coefficient computation over the stored samples.
REQ-011 SHALL have port clear, input, 1: discard stored samples (IDLE only).
REQ-012 SHALL have port sampleCount, output, CW: number of stored samples.
REQ-013 SHALL have port busy, output, 1: computation in progress.
REQ-014 SHALL have port calcReady, output, 1: one-cycle pulse when outB0, outB1 and err are valid.
REQ-015 SHALL have port err, output, 1: last computation degenerate (count 0 or SSxx = 0).
REQ-016 SHALL have port outB0, output, W: intercept.
REQ-017 SHALL have port outB1, output, W: slope.

Function
REQ-018 SHALL implement states IDLE, SUM, MEANX, MEANY, DEV, DIVB1, CALCB0, DONE.
REQ-019 SHALL, in IDLE, assert inReady iff sampleCount < DEPTH; on inValid && inReady, write (inX, inY) to buffer[sampleCount] and increment sampleCount.
REQ-020 SHALL, when sampleCount = DEPTH, hold inReady low and accept no further sample.
REQ-021 SHALL, on clear in IDLE, set sampleCount to 0 in the next cycle; clear outside IDLE SHALL be ignored.
REQ-022 SHALL give calcStart priority over a simultaneous inValid (that sample is not stored) and over a simultaneous clear.
REQ-023 SHALL, on calcStart in IDLE with sampleCount = 0, go directly to DONE with err = 1, outB0 = 0, outB1 = 0.
REQ-024 SHALL, on calcStart in IDLE with sampleCount > 0, enter SUM and read one sample per cycle, accumulating sumX and sumY in signed accumulators of width W+CW.
REQ-025 SHALL compute xbar = sumX / count in MEANX and ybar = sumY / count in MEANY, using one shared sequential signed divider, result truncated toward zero to W bits.
REQ-026 SHALL, in DEV, read one sample per cycle and accumulate SSxx += (xi-xbar)^2 and SSxy += (xi-xbar)(yi-ybar), with products rescaled by >>> FRAC, in signed accumulators of width 2W+CW.
REQ-027 SHALL, in DIVB1, compute B1 = (SSxy << FRAC) / SSxx, truncated toward zero, saturated to the W-bit signed range.
REQ-028 SHALL, if SSxx = 0, skip the division and set B1 = 0, err = 1.
REQ-029 SHALL, in CALCB0, compute B0 = ybar - ((B1 * xbar) >>> FRAC), saturated to W bits.
REQ-030 SHALL, in DONE, register outB0, outB1 and err, pulse calcReady for exactly one cycle, and return to IDLE.
REQ-031 SHALL hold outB0, outB1 and err stable until the next DONE.
REQ-032 SHALL preserve stored samples after a computation, so a repeated calcStart reproduces identical results.
REQ-033 SHALL hold busy = 1 in every state except IDLE, and hold inReady = 0 while busy.
REQ-034 SHALL ignore calcStart while busy.
REQ-035 SHALL assert calcReady no later than 2*count + 3*(2W+CW) + 10 cycles after calcStart.

Reset
REQ-036 SHALL, on rst, enter IDLE and set sampleCount, outB0, outB1, err, calcReady and busy to 0 in the next cycle, regardless of state; an aborted computation produces no calcReady.
REQ-037 SHALL not require buffer contents to be reset; sampleCount = 0 makes them unreachable.

Verification
REQ-038 SHALL be verified (W=20, FRAC=10) with samples x = 1024, 2048, 3072 and y = 3072, 5120, 7168, then calcStart -> calcReady pulse once, outB1 = 2048, outB0 = 1024, err = 0.
REQ-039 SHALL be verified with calcStart at sampleCount = 0 -> calcReady, err = 1, outB0 = 0, outB1 = 0.
REQ-040 SHALL be verified with three samples of x = 2048, y = 1024, 2048, 3072 -> err = 1, outB1 = 0, outB0 = 2048.
REQ-041 SHALL be verified with DEPTH = 4: offer 5 samples back to back -> inReady low after the 4th, sampleCount = 4, 5th not stored.
REQ-042 SHALL be verified by asserting rst during DEV -> next cycle busy = 0, sampleCount = 0, outputs 0, no calcReady.
REQ-043 SHALL be verified with calcStart, inValid and clear in the same IDLE cycle -> computation starts, sample dropped, count unchanged.
